// File: rtl/mano_pkg.sv
// Shared constants and types for the Mano common-bus register bank.
// Bus select codes and register indices match the default six-register build.
package mano_pkg;

  localparam int unsigned SEL_NONE = 0;
  localparam int unsigned SEL_AR   = 1;
  localparam int unsigned SEL_PC   = 2;
  localparam int unsigned SEL_DR   = 3;
  localparam int unsigned SEL_AC   = 4;
  localparam int unsigned SEL_IR   = 5;
  localparam int unsigned SEL_TR   = 6;
  localparam int unsigned SEL_MEM  = 7;

  localparam int unsigned REG_AR = 0;
  localparam int unsigned REG_PC = 1;
  localparam int unsigned REG_DR = 2;
  localparam int unsigned REG_AC = 3;
  localparam int unsigned REG_IR = 4;
  localparam int unsigned REG_TR = 5;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LD,
    OP_INC,
    OP_DEC,
    OP_CLR
  } reg_op_e;

endpackage

// File: rtl/mano_bus_reg.sv
// One bus register of width W with ld > inc > dec > clr priority and a
// registered wrap pulse; output is zero-extended to FULL_W.
module mano_bus_reg
  import mano_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned FULL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      bus,
  input  logic              ld,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [FULL_W-1:0] q,
  output logic              wrap
);

  reg_op_e        op;
  logic [W-1:0]   val_q, val_d;
  logic           wrap_q, wrap_d;

  always_comb begin
    op = OP_HOLD;
    if (ld)       op = OP_LD;
    else if (inc) op = OP_INC;
    else if (dec) op = OP_DEC;
    else if (clr) op = OP_CLR;
  end

  always_comb begin
    val_d  = val_q;
    wrap_d = 1'b0;
    unique case (op)
      OP_LD:   val_d = bus;
      OP_INC: begin
        val_d  = val_q + W'(1);
        wrap_d = (val_q == {W{1'b1}});
      end
      OP_DEC: begin
        val_d  = val_q - W'(1);
        wrap_d = (val_q == '0);
      end
      OP_CLR:  val_d = '0;
      default: val_d = val_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = FULL_W'(val_q);
  assign wrap = wrap_q;

endmodule

// File: rtl/mano_bus_regbank.sv
// Mano basic-computer register bank: common-bus mux, NUM_REGS registers
// with per-register ld/inc/dec/clr, and the sequence counter with T decode.
module mano_bus_regbank
  import mano_pkg::*;
#(
  parameter int unsigned         WIDTH       = 16,
  parameter int unsigned         ADDR_WIDTH  = 12,
  parameter int unsigned         NUM_REGS    = 6,
  parameter logic [NUM_REGS-1:0] NARROW_MASK = 6'b000011,
  parameter int unsigned         SEL_W       = $clog2(NUM_REGS + 2),
  parameter int unsigned         SC_W        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          bus_sel,
  input  logic [WIDTH-1:0]          mem_rdata,
  input  logic [NUM_REGS-1:0]       ld,
  input  logic [NUM_REGS-1:0]       inc,
  input  logic [NUM_REGS-1:0]       dec,
  input  logic [NUM_REGS-1:0]       clr,
  input  logic                      sc_inc,
  input  logic                      sc_clr,
  output logic [WIDTH-1:0]          bus_out,
  output logic [NUM_REGS*WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]       wrap,
  output logic [SC_W-1:0]           sc_q,
  output logic [(1<<SC_W)-1:0]      t
);

  logic [WIDTH-1:0] reg_arr [NUM_REGS];
  logic [SC_W-1:0]  sc_d;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam int unsigned RW = NARROW_MASK[i] ? ADDR_WIDTH : WIDTH;

    // Narrow registers see only the low bits of the bus, which truncates loads.
    mano_bus_reg #(
      .W      (RW),
      .FULL_W (WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_out[RW-1:0]),
      .ld    (ld[i]),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .clr   (clr[i]),
      .q     (reg_arr[i]),
      .wrap  (wrap[i])
    );

    assign reg_q[i*WIDTH +: WIDTH] = reg_arr[i];
  end

  always_comb begin
    bus_out = '0;
    if (bus_sel == SEL_W'(NUM_REGS + 1)) begin
      bus_out = mem_rdata;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus_sel == SEL_W'(i + 1)) bus_out = reg_arr[i];
      end
    end
  end

  always_comb begin
    sc_d = sc_q;
    if (sc_clr)      sc_d = '0;
    else if (sc_inc) sc_d = sc_q + SC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sc_q <= '0;
    else        sc_q <= sc_d;
  end

  always_comb begin
    t       = '0;
    t[sc_q] = 1'b1;
  end

endmodule

// File: tb/tb_mano_bus_regbank.sv
// Self-checking bench for mano_bus_regbank: directed vector table, SC and
// async-reset sequences, then randomized traffic against a behavioural model.
module tb_mano_bus_regbank;

  localparam int NR = 6;
  localparam logic [5:0] NMASK = 6'b000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  bus_sel;
  logic [15:0] mem_rdata;
  logic [5:0]  ld, inc, dec, clr;
  logic        sc_inc, sc_clr;
  logic [15:0] bus_out;
  logic [95:0] reg_q;
  logic [5:0]  wrap;
  logic [3:0]  sc_q;
  logic [15:0] t;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int         m_reg [NR];
  logic [5:0] m_wrap;
  int         m_sc;

  always #5 clk = ~clk;

  mano_bus_regbank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_sel   (bus_sel),
    .mem_rdata (mem_rdata),
    .ld        (ld),
    .inc       (inc),
    .dec       (dec),
    .clr       (clr),
    .sc_inc    (sc_inc),
    .sc_clr    (sc_clr),
    .bus_out   (bus_out),
    .reg_q     (reg_q),
    .wrap      (wrap),
    .sc_q      (sc_q),
    .t         (t)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] mem;
    logic [5:0]  v_ld, v_inc, v_dec, v_clr;
    logic [15:0] exp_bus;
    int          idx;
    logic [15:0] exp_val;
    logic [5:0]  exp_wrap;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [15:0] m, input logic [5:0] l,
                       input logic [5:0] in, input logic [5:0] de, input logic [5:0] cl,
                       input logic si, input logic sclr);
    bus_sel = s; mem_rdata = m; ld = l; inc = in; dec = de; clr = cl;
    sc_inc = si; sc_clr = sclr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int reg_w(input int i);
    return NMASK[i] ? 12 : 16;
  endfunction

  function automatic logic [15:0] model_bus();
    if (bus_sel == 3'd0) return 16'h0;
    if (bus_sel == 3'd7) return mem_rdata;
    return 16'(m_reg[int'(bus_sel) - 1]);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [15:0] b;
    b = model_bus();
    for (int i = 0; i < NR; i++) begin
      int mx, v;
      mx = (1 << reg_w(i)) - 1;
      v  = m_reg[i];
      m_wrap[i] = 1'b0;
      if (ld[i]) v = int'(b) & mx;
      else if (inc[i]) begin m_wrap[i] = (v == mx); v = (v + 1) & mx; end
      else if (dec[i]) begin m_wrap[i] = (v == 0);  v = (v - 1) & mx; end
      else if (clr[i]) v = 0;
      m_reg[i] = v;
    end
    if (sc_clr)      m_sc = 0;
    else if (sc_inc) m_sc = (m_sc + 1) % 16;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    m_wrap = '0;
    m_sc   = 0;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg%0d", tag, i), 64'(reg_q[i*16 +: 16]), 64'(m_reg[i]));
    check({tag, " wrap"}, 64'(wrap), 64'(m_wrap));
    check({tag, " sc"}, 64'(sc_q), 64'(m_sc));
    check({tag, " t"}, 64'(t), 64'(32'd1 << m_sc));
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{3'd7, 16'hABCD, 6'b000101, 6'b0, 6'b0, 6'b0, 16'hABCD, 2, 16'hABCD, 6'b0};
    vecs[1]  = '{3'd1, 16'h0000, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0BCD, 0, 16'h0BCD, 6'b0};
    vecs[2]  = '{3'd0, 16'h0000, 6'b0, 6'b0, 6'b000010, 6'b0, 16'h0000, 1, 16'h0FFF, 6'b000010};
    vecs[3]  = '{3'd2, 16'h0000, 6'b0, 6'b000010, 6'b0, 6'b0, 16'h0FFF, 1, 16'h0000, 6'b000010};
    vecs[4]  = '{3'd2, 16'h0000, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0000, 1, 16'h0000, 6'b0};
    vecs[5]  = '{3'd4, 16'h0000, 6'b0, 6'b0, 6'b001000, 6'b0, 16'h0000, 3, 16'hFFFF, 6'b001000};
    vecs[6]  = '{3'd4, 16'h0000, 6'b0, 6'b001000, 6'b0, 6'b0, 16'hFFFF, 3, 16'h0000, 6'b001000};
    vecs[7]  = '{3'd4, 16'h0000, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0000, 3, 16'h0000, 6'b0};
    vecs[8]  = '{3'd7, 16'h0055, 6'b000100, 6'b0, 6'b0, 6'b0, 16'h0055, 2, 16'h0055, 6'b0};
    vecs[9]  = '{3'd7, 16'h0010, 6'b001000, 6'b0, 6'b0, 6'b0, 16'h0010, 3, 16'h0010, 6'b0};
    vecs[10] = '{3'd3, 16'h0000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 16'h0055, 3,
                 16'h0055, 6'b0};
    vecs[11] = '{3'd4, 16'h0000, 6'b0, 6'b001000, 6'b0, 6'b001000, 16'h0055, 3, 16'h0056, 6'b0};
    vecs[12] = '{3'd6, 16'h0000, 6'b0, 6'b0, 6'b100000, 6'b0, 16'h0000, 5, 16'hFFFF, 6'b100000};
    vecs[13] = '{3'd6, 16'h0000, 6'b0, 6'b0, 6'b100000, 6'b0, 16'hFFFF, 5, 16'hFFFE, 6'b0};

    rst_n = 1'b0;
    drive(3'd0, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    #12;
    check("reset reg_q", 64'(reg_q[63:0]), 64'h0);
    check("reset reg_q hi", 64'(reg_q[95:64]), 64'h0);
    check("reset sc", 64'(sc_q), 64'h0);
    check("reset t", 64'(t), 64'h1);
    check("reset wrap", 64'(wrap), 64'h0);
    #1 rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].sel, vecs[k].mem, vecs[k].v_ld, vecs[k].v_inc, vecs[k].v_dec,
            vecs[k].v_clr, 1'b0, 1'b0);
      #1;
      check($sformatf("vec%0d bus", k), 64'(bus_out), 64'(vecs[k].exp_bus));
      tick();
      check($sformatf("vec%0d reg", k), 64'(reg_q[vecs[k].idx*16 +: 16]),
            64'(vecs[k].exp_val));
      check($sformatf("vec%0d wrap", k), 64'(wrap), 64'(vecs[k].exp_wrap));
    end
    check("AR narrow after load", 64'(reg_q[15:0]), 64'h0BCD);

    // Sequence counter walk
    drive(3'd0, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("sc walk t%0d", k), 64'(t), 64'(32'd1 << k));
      tick();
    end
    check("sc wrap value", 64'(sc_q), 64'h0);
    check("sc wrap t", 64'(t), 64'h1);
    tick(); tick(); tick();
    check("sc at 3", 64'(sc_q), 64'h3);
    drive(3'd0, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b1, 1'b1);
    tick();
    check("sc clr priority", 64'(sc_q), 64'h0);

    // Mid-cycle async reset with AC=1234, SC=5
    drive(3'd7, 16'h1234, 6'b001000, 6'b0, 6'b0, 6'b0, 1'b1, 1'b0);
    tick();
    drive(3'd0, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    drive(3'd0, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    check("pre-reset AC", 64'(reg_q[63:48]), 64'h1234);
    check("pre-reset sc", 64'(sc_q), 64'h5);
    #2 rst_n = 1'b0;
    #1;
    check("async reset AC", 64'(reg_q[63:48]), 64'h0);
    check("async reset sc", 64'(sc_q), 64'h0);
    check("async reset t", 64'(t), 64'h1);
    drive(3'd4, 16'h0, 6'b0, 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
    #1;
    check("reset bus follows sel", 64'(bus_out), 64'h0);
    #1 rst_n = 1'b1;
    model_reset();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        drive(3'($urandom_range(0, 7)), 16'($urandom), 6'b0, 6'b0, 6'b0, 6'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rand rst");
        #1 rst_n = 1'b1;
      end else begin
        drive(3'($urandom_range(0, 7)), 16'($urandom),
              6'($urandom) & 6'($urandom) & 6'($urandom),
              6'($urandom) & 6'($urandom), 6'($urandom) & 6'($urandom),
              6'($urandom) & 6'($urandom) & 6'($urandom),
              1'($urandom), ($urandom_range(0, 7) == 0));
        #1;
        check("rand bus", 64'(bus_out), 64'(model_bus()));
      end
      model_edge();
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
